fetch_queue: RTL

- Instruction fetch buffer between the instruction memory read port and the decode/control stage.
- Captures each (PC, instruction) pair read from instruction memory into a small FIFO and presents it to decode with a valid/ready handshake.
- Back-pressures the PC register through fetch_en.
- Discards buffered instructions when a taken branch (PCsrc) flushes the stream.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the instruction memory read
// port and decode. Holds DEPTH {pc, instr} pairs in a circular buffer, hands
// the head to decode with valid/ready, stalls the PC through fetch_en and
// drops everything buffered on a taken branch (flush).
//
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and no
// flush is pending, the incoming pair is presented to decode in the same
// cycle and is only stored if decode does not take it.
module fetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDRESS_WIDTH-1:0]   pc_in,
  input  logic [DATA_WIDTH-1:0]      instr_in,
  input  logic                       flush,
  output logic                       fetch_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [ADDRESS_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];

  ptr_t rd_ptr;
  ptr_t wr_ptr;
  logic empty;
  logic bypass;
  logic deq;
  logic enq;
  logic wr_en;
  logic rd_en;

  assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Pass-through is only offered while nothing older is waiting.
  assign bypass = empty && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Head presentation: stored head when occupied, the live fetch pair in bypass.
  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = pc_in;
      out_instr = instr_in;
    end
  end

  assign deq      = out_valid && out_ready;
  assign fetch_en = flush || (count < FULL) || deq;
  assign enq      = fetch_en && !flush;
  // A bypassed pair that decode accepts has already been consumed.
  assign wr_en    = enq && !(bypass && out_ready);
  // Only an occupied queue gives up a stored entry.
  assign rd_en    = deq && !empty;

  // Entry storage, written at the tail on every accepted fetch.
  // NOTE: storage is deliberately not reset; count/out_valid guard its contents.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      pc_mem[wr_ptr]    <= pc_in;
      instr_mem[wr_ptr] <= instr_in;
    end
  end

  // Pointer and occupancy bookkeeping; reset beats flush beats enq/deq.
  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Occupancy must stay within the buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count <= FULL)
    else $error("fetch_queue: count above DEPTH");

  // A stored entry is only released when one exists.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) rd_en |-> !empty)
    else $error("fetch_queue: read from empty queue");
`endif

endmodule
